// File: rtl/mdio_responder_if.sv
// Register-file port of the MDIO responder: address, read/write strobes and data.
// master = responder side, slave = local register file.
interface mdio_responder_if;
  logic [4:0]  reg_addr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        reg_wr;
  logic [15:0] reg_wdata;

  modport master (output reg_addr, reg_rd, reg_wr, reg_wdata, input reg_rdata);
  modport slave  (input reg_addr, reg_rd, reg_wr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder; decodes frames for PHY_ADDR onto a 32x16 register port.
// Latency: mdio_o/mdio_t 1 clk after synchronised mdc rise; reg_rd/reg_wr 1 clk after the last field bit.
// No backpressure. `define MDIO_PREAMBLE_SUPPRESS_EN to accept ST after any nonzero preamble.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mdc,
  input  logic             mdio_i,
  output logic             mdio_o,
  output logic             mdio_t,
  output logic             frame_err,
  mdio_responder_if.master regs
);
  localparam int            PW      = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    mdc_sync, mdio_sync;
  logic          mdc_d, mdc_rise, mdio_s;
  logic [PW-1:0] pre_cnt;
  logic [4:0]    bit_cnt;
  logic [14:0]   in_sh;
  logic [15:0]   tx_sh;
  logic          is_rd, cap_pend, err, pre_ok;
  logic [4:0]    reg_addr_q;
  logic [15:0]   reg_wdata_q;
  logic          reg_rd_q, reg_wr_q;

  assign regs.reg_addr  = reg_addr_q;
  assign regs.reg_wdata = reg_wdata_q;
  assign regs.reg_rd    = reg_rd_q;
  assign regs.reg_wr    = reg_wr_q;

  // Synchronisers are left out of reset so a mid-frame reset cannot fake an mdc edge.
  always_ff @(posedge clk) begin
    mdc_sync  <= {mdc_sync[0], mdc};
    mdio_sync <= {mdio_sync[0], mdio_i};
    mdc_d     <= mdc_sync[1];
  end

  assign mdc_rise = mdc_sync[1] & ~mdc_d;
  assign mdio_s   = mdio_sync[1];

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign pre_ok = (pre_cnt != '0);
`else
  assign pre_ok = (pre_cnt == PRE_MAX);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    if (mdc_rise) begin
      case (state)
        S_IDLE:  if (!mdio_s && pre_ok) state_nxt = S_ST;
        S_ST: begin
          if (mdio_s) state_nxt = S_OP;
          else begin
            err       = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        // in_sh[0] holds the first opcode bit; only 10 and 01 are legal
        S_OP: begin
          if (bit_cnt[0]) begin
            if (in_sh[0] != mdio_s) state_nxt = S_PHYAD;
            else begin
              err       = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        S_PHYAD: if (bit_cnt == 5'd4)
                   state_nxt = ({in_sh[3:0], mdio_s} == PHY_ADDR) ? S_REGAD : S_SKIP;
        S_REGAD: if (bit_cnt == 5'd4)  state_nxt = S_TA;
        S_TA:    if (bit_cnt == 5'd1)  state_nxt = S_DATA;
        S_DATA:  if (bit_cnt == 5'd15) state_nxt = S_IDLE;
        S_SKIP:  if (bit_cnt == 5'd22) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      bit_cnt     <= '0;
      in_sh       <= '0;
      tx_sh       <= '0;
      is_rd       <= 1'b0;
      cap_pend    <= 1'b0;
      mdio_o      <= 1'b0;
      mdio_t      <= 1'b1;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      reg_rd_q  <= 1'b0;
      reg_wr_q  <= 1'b0;
      frame_err <= err;
      cap_pend  <= reg_rd_q;
      if (cap_pend) tx_sh <= regs.reg_rdata;
      if (state != S_IDLE) pre_cnt <= '0;
      if (mdc_rise) begin
        in_sh   <= {in_sh[13:0], mdio_s};
        bit_cnt <= (state_nxt != state) ? 5'd0 : bit_cnt + 5'd1;
        if (state == S_IDLE)
          pre_cnt <= !mdio_s ? '0 : (pre_cnt == PRE_MAX) ? pre_cnt : pre_cnt + PW'(1);
        case (state)
          S_OP: if (bit_cnt[0]) is_rd <= in_sh[0];
          S_REGAD: begin
            if (bit_cnt == 5'd4) begin
              reg_addr_q <= {in_sh[3:0], mdio_s};
              reg_rd_q   <= is_rd;
            end
          end
          S_TA: begin
            if (is_rd) begin
              if (bit_cnt == 5'd0) begin
                mdio_t <= 1'b0;
                mdio_o <= 1'b0;
              end else begin
                mdio_o <= tx_sh[15];
                tx_sh  <= {tx_sh[14:0], 1'b0};
              end
            end
          end
          S_DATA: begin
            if (is_rd) begin
              if (bit_cnt == 5'd15) begin
                mdio_t <= 1'b1;
                mdio_o <= 1'b0;
              end else begin
                mdio_o <= tx_sh[15];
                tx_sh  <= {tx_sh[14:0], 1'b0};
              end
            end else if (bit_cnt == 5'd15) begin
              reg_wdata_q <= {in_sh, mdio_s};
              reg_wr_q    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
